// File: rtl/r_alu_seq_if.sv
// Request/response bundle for the sequential R-type execute unit.
// master = decode/writeback side, slave = r_alu_seq.
interface r_alu_seq_if;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] rs1_val;
    logic [31:0] rs2_val;
    logic [4:0]  rd_addr;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic [4:0]  out_rd;
    logic        illegal;

    modport master (
        output in_valid, funct3, funct7, rs1_val, rs2_val, rd_addr, out_ready,
        input  in_ready, out_valid, result, out_rd, illegal
    );

    modport slave (
        input  in_valid, funct3, funct7, rs1_val, rs2_val, rd_addr, out_ready,
        output in_ready, out_valid, result, out_rd, illegal
    );
endinterface

// File: rtl/r_alu_seq.sv
// Sequential RV32I R-type execute unit: one op in over valid/ready, result out over valid/ready.
// Shifts iterate one bit per cycle unless R_ALU_BARREL_SHIFT_EN is defined (single-cycle shifts).
module r_alu_seq (
    input  logic       clk,
    input  logic       rst,
    r_alu_seq_if.slave bus
);
    localparam int XLEN = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        DONE  = 2'b10
    } state_e;

    state_e            state_r;
    state_e            state_nxt_s;
    logic              in_ready_r;
    logic              out_valid_r;
    logic              illegal_r;
    logic              illegal_nxt_s;
    logic [XLEN-1:0]   result_r;
    logic [XLEN-1:0]   result_nxt_s;
    logic [4:0]        out_rd_r;
    logic [4:0]        out_rd_nxt_s;
    logic              fire_in_s;
    logic              legal_s;
    logic [XLEN-1:0]   alu_s;

    // Legal funct7 values: only ADD/SUB and SRL/SRA use the 0x20 alternate encoding.
    function automatic logic op_legal_f(input logic [2:0] f3, input logic [6:0] f7);
        logic ok;
        case (f3)
            3'b000, 3'b101: ok = (f7 == 7'h00) || (f7 == 7'h20);
            default:        ok = (f7 == 7'h00);
        endcase
        return ok;
    endfunction

    // Single-cycle result for a legal op; alt selects SUB/SRA.
    function automatic logic [XLEN-1:0] alu_f(
        input logic [2:0]      f3,
        input logic            alt,
        input logic [XLEN-1:0] a,
        input logic [XLEN-1:0] b
    );
        logic [XLEN-1:0] r;
        case (f3)
            3'b000:  r = alt ? (a - b) : (a + b);
`ifdef R_ALU_BARREL_SHIFT_EN
            3'b001:  r = a << b[4:0];
            3'b101:  r = alt ? $unsigned($signed(a) >>> b[4:0]) : (a >> b[4:0]);
`else
            // Only the shamt==0 case completes here; non-zero shifts iterate.
            3'b001:  r = a;
            3'b101:  r = a;
`endif
            3'b010:  r = ($signed(a) < $signed(b)) ? 32'h0000_0001 : 32'h0000_0000;
            3'b011:  r = (a < b) ? 32'h0000_0001 : 32'h0000_0000;
            3'b100:  r = a ^ b;
            3'b110:  r = a | b;
            3'b111:  r = a & b;
            default: r = {XLEN{1'b0}};
        endcase
        return r;
    endfunction

`ifndef R_ALU_BARREL_SHIFT_EN
    typedef enum logic [1:0] {
        SH_SLL = 2'b00,
        SH_SRL = 2'b01,
        SH_SRA = 2'b10
    } shift_e;

    shift_e     shift_kind_r;
    shift_e     shift_kind_nxt_s;
    shift_e     shift_kind_s;
    logic [4:0] count_r;
    logic [4:0] count_nxt_s;
    logic       shift_op_s;

    // SRA refills with bit 31, which an arithmetic shift never changes.
    function automatic logic [XLEN-1:0] shift_one_f(input shift_e kind, input logic [XLEN-1:0] w);
        logic [XLEN-1:0] r;
        case (kind)
            SH_SLL:  r = {w[XLEN-2:0], 1'b0};
            SH_SRL:  r = {1'b0, w[XLEN-1:1]};
            SH_SRA:  r = {w[XLEN-1], w[XLEN-1:1]};
            default: r = w;
        endcase
        return r;
    endfunction

    assign shift_op_s   = (bus.funct3 == 3'b001) || (bus.funct3 == 3'b101);
    assign shift_kind_s = (bus.funct3 == 3'b001) ? SH_SLL : (bus.funct7[5] ? SH_SRA : SH_SRL);
`endif

    assign fire_in_s = bus.in_valid & in_ready_r;
    assign legal_s   = op_legal_f(bus.funct3, bus.funct7);
    assign alu_s     = legal_s ? alu_f(bus.funct3, bus.funct7[5], bus.rs1_val, bus.rs2_val)
                               : {XLEN{1'b0}};

    // Next-state and next-output logic; result_r doubles as the shift working register.
    always_comb begin
        state_nxt_s   = state_r;
        result_nxt_s  = result_r;
        out_rd_nxt_s  = out_rd_r;
        illegal_nxt_s = illegal_r;
`ifndef R_ALU_BARREL_SHIFT_EN
        count_nxt_s      = count_r;
        shift_kind_nxt_s = shift_kind_r;
`endif
        case (state_r)
            IDLE: begin
                if (fire_in_s) begin
                    out_rd_nxt_s  = bus.rd_addr;
                    illegal_nxt_s = ~legal_s;
                    result_nxt_s  = alu_s;
                    state_nxt_s   = DONE;
`ifndef R_ALU_BARREL_SHIFT_EN
                    count_nxt_s      = bus.rs2_val[4:0];
                    shift_kind_nxt_s = shift_kind_s;
                    if (legal_s && shift_op_s && (bus.rs2_val[4:0] != 5'd0)) begin
                        result_nxt_s = bus.rs1_val;
                        state_nxt_s  = SHIFT;
                    end else begin
                        state_nxt_s  = DONE;
                    end
`endif
                end else begin
                    state_nxt_s = IDLE;
                end
            end
`ifndef R_ALU_BARREL_SHIFT_EN
            SHIFT: begin
                result_nxt_s = shift_one_f(shift_kind_r, result_r);
                count_nxt_s  = count_r - 5'd1;
                // The last bit shifts on the same edge that raises out_valid.
                if (count_r == 5'd1) begin
                    state_nxt_s = DONE;
                end else begin
                    state_nxt_s = SHIFT;
                end
            end
`endif
            DONE: begin
                if (bus.out_ready) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = DONE;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // State and registered outputs; handshake flags follow the next state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= IDLE;
            in_ready_r  <= 1'b0;
            out_valid_r <= 1'b0;
            result_r    <= {XLEN{1'b0}};
            out_rd_r    <= 5'd0;
            illegal_r   <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            in_ready_r  <= (state_nxt_s == IDLE);
            out_valid_r <= (state_nxt_s == DONE);
            result_r    <= result_nxt_s;
            out_rd_r    <= out_rd_nxt_s;
            illegal_r   <= illegal_nxt_s;
        end
    end

`ifndef R_ALU_BARREL_SHIFT_EN
    // Iterative shifter bookkeeping: remaining count and shift flavour.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_r      <= 5'd0;
            shift_kind_r <= SH_SLL;
        end else begin
            count_r      <= count_nxt_s;
            shift_kind_r <= shift_kind_nxt_s;
        end
    end
`endif

    assign bus.in_ready  = in_ready_r;
    assign bus.out_valid = out_valid_r;
    assign bus.result    = result_r;
    assign bus.out_rd    = out_rd_r;
    assign bus.illegal   = illegal_r;
endmodule

// File: tb/tb_r_alu_seq.sv
// Self-checking bench for r_alu_seq: directed cases plus randomized ops against a behavioural model.
module tb_r_alu_seq;
`ifdef R_ALU_BARREL_SHIFT_EN
    localparam bit BARREL = 1'b1;
`else
    localparam bit BARREL = 1'b0;
`endif

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    r_alu_seq_if bus();

    r_alu_seq u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference: RV32I R-type semantics straight from the ISA rules.
    function automatic void model(
        input  logic [2:0]  f3,
        input  logic [6:0]  f7,
        input  logic [31:0] a,
        input  logic [31:0] b,
        output logic [31:0] r,
        output logic        ill,
        output int          lat
    );
        int sh;
        sh  = int'(b[4:0]);
        r   = 32'h0;
        ill = 1'b0;
        case (f3)
            3'd0: if (f7 == 7'h00) r = a + b; else if (f7 == 7'h20) r = a - b; else ill = 1'b1;
            3'd1: if (f7 == 7'h00) r = a << sh; else ill = 1'b1;
            3'd2: if (f7 == 7'h00) r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0; else ill = 1'b1;
            3'd3: if (f7 == 7'h00) r = (a < b) ? 32'd1 : 32'd0; else ill = 1'b1;
            3'd4: if (f7 == 7'h00) r = a ^ b; else ill = 1'b1;
            3'd5: if (f7 == 7'h00) r = a >> sh;
                  else if (f7 == 7'h20) r = $unsigned($signed(a) >>> sh);
                  else ill = 1'b1;
            3'd6: if (f7 == 7'h00) r = a | b; else ill = 1'b1;
            default: if (f7 == 7'h00) r = a & b; else ill = 1'b1;
        endcase
        lat = (!ill && (f3 == 3'd1 || f3 == 3'd5) && !BARREL) ? sh : 0;
    endfunction

    task automatic drive(input logic [2:0] f3, input logic [6:0] f7,
                         input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd);
        bus.funct3  = f3;
        bus.funct7  = f7;
        bus.rs1_val = a;
        bus.rs2_val = b;
        bus.rd_addr = rd;
    endtask

    // Waits (bounded) for in_ready, presents the op at a negedge, returns just after the accept edge.
    task automatic send(input logic [2:0] f3, input logic [6:0] f7,
                        input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd);
        int n;
        n = 0;
        @(negedge clk);
        while (!bus.in_ready && n < 8) begin
            @(negedge clk);
            n++;
        end
        chk("in_ready_wait", 32'(bus.in_ready), 32'd1);
        drive(f3, f7, a, b, rd);
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        drive(3'($urandom), 7'($urandom), $urandom, $urandom, 5'($urandom));
    endtask

    // Checks latency and outputs, holds off out_ready for 'hold' cycles, then drains.
    task automatic expect_result(input logic [31:0] exp, input logic [4:0] rd,
                                 input logic ill, input int lat, input int hold);
        int cyc;
        cyc = 0;
        @(negedge clk);
        while (!bus.out_valid && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
        chk("latency", 32'(cyc), 32'(lat));
        chk("result", bus.result, exp);
        chk("out_rd", 32'(bus.out_rd), 32'(rd));
        chk("illegal", 32'(bus.illegal), 32'(ill));
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk("hold_valid", 32'(bus.out_valid), 32'd1);
            chk("hold_result", bus.result, exp);
            chk("hold_rd", 32'(bus.out_rd), 32'(rd));
            chk("hold_in_ready", 32'(bus.in_ready), 32'd0);
        end
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        @(negedge clk);
        chk("drain_valid", 32'(bus.out_valid), 32'd0);
        chk("drain_in_ready", 32'(bus.in_ready), 32'd1);
    endtask

    task automatic run_op(input logic [2:0] f3, input logic [6:0] f7,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] rd, input int hold);
        logic [31:0] r;
        logic        ill;
        int          lat;
        model(f3, f7, a, b, r, ill, lat);
        send(f3, f7, a, b, rd);
        expect_result(r, rd, ill, lat, hold);
    endtask

    initial begin
        logic [31:0] r;
        logic        ill;
        int          lat;
        int          viol;
        logic [6:0]  f7;
        logic [31:0] b;
        checks = 0;
        errors = 0;

        // Reset with a request pending: nothing may be captured.
        rst           = 1'b1;
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        drive(3'b000, 7'h00, 32'h1234_5678, 32'h1111_1111, 5'd7);
        @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_result", bus.result, 32'h0);
        chk("rst_out_rd", 32'(bus.out_rd), 32'd0);
        chk("rst_illegal", 32'(bus.illegal), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        @(negedge clk);
        chk("post_rst_in_ready", 32'(bus.in_ready), 32'd1);
        chk("post_rst_out_valid", 32'(bus.out_valid), 32'd0);
        @(negedge clk);
        chk("no_capture", 32'(bus.out_valid), 32'd0);

        // Directed single-cycle and arithmetic cases.
        run_op(3'b111, 7'h00, 32'h5555_5555, 32'hAAAA_AAAA, 5'd3, 0);
        run_op(3'b111, 7'h00, 32'hFFFF_FFFF, 32'h0000_000F, 5'd17, 0);
        run_op(3'b000, 7'h20, 32'h0000_0000, 32'h0000_0001, 5'd4, 0);
        run_op(3'b010, 7'h00, 32'hFFFF_FFFF, 32'h0000_0001, 5'd5, 0);
        run_op(3'b011, 7'h00, 32'hFFFF_FFFF, 32'h0000_0001, 5'd6, 0);
        chk("sub_wrap_model", 32'hFFFF_FFFF, 32'h0000_0000 - 32'h0000_0001);

        // Shifts: worst-case SRA and shamt=0.
        run_op(3'b101, 7'h20, 32'h8000_0000, 32'h0000_001F, 5'd8, 0);
        run_op(3'b101, 7'h20, 32'h8000_0000, 32'h0000_0000, 5'd9, 0);

        // Backpressure for 5 cycles; illegal encoding.
        run_op(3'b111, 7'h00, 32'hDEAD_BEEF, 32'h0F0F_F0F0, 5'd31, 5);
        run_op(3'b111, 7'h20, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd10, 0);
        run_op(3'b001, 7'h20, 32'h0000_0001, 32'h0000_0004, 5'd11, 1);

        // A request held during DONE and the drain edge is taken only in the next IDLE cycle.
        send(3'b100, 7'h00, 32'h0000_FFFF, 32'h0F0F_0F0F, 5'd12);
        @(negedge clk);
        chk("pend_a_valid", 32'(bus.out_valid), 32'd1);
        chk("pend_a_result", bus.result, 32'h0F0F_F0F0);
        drive(3'b110, 7'h00, 32'h1200_0034, 32'h0056_7800, 5'd13);
        bus.in_valid = 1'b1;
        repeat (2) begin
            @(negedge clk);
            chk("pend_in_ready", 32'(bus.in_ready), 32'd0);
        end
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        @(negedge clk);
        chk("pend_drain_valid", 32'(bus.out_valid), 32'd0);
        chk("pend_drain_in_ready", 32'(bus.in_ready), 32'd1);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        @(negedge clk);
        chk("pend_b_valid", 32'(bus.out_valid), 32'd1);
        chk("pend_b_result", bus.result, 32'h1256_7834);
        chk("pend_b_rd", 32'(bus.out_rd), 32'd13);
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;

        // Reset in the middle of a long SLL discards it.
        send(3'b001, 7'h00, 32'h0000_0001, 32'h0000_0014, 5'd14);
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("mid_rst_valid", 32'(bus.out_valid), 32'd0);
        chk("mid_rst_in_ready", 32'(bus.in_ready), 32'd0);
        viol = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (bus.out_valid) viol++;
        end
        chk("mid_rst_no_output", 32'(viol), 32'd0);
        chk("mid_rst_idle", 32'(bus.in_ready), 32'd1);

        // Randomized ops against the model.
        for (int n = 0; n < 40; n++) begin
            case ($urandom_range(0, 9))
                0, 1, 2, 3, 4, 5: f7 = 7'h00;
                6, 7, 8:          f7 = 7'h20;
                default:          f7 = 7'($urandom);
            endcase
            b = $urandom;
            if ($urandom_range(0, 3) == 0) b[4:0] = 5'd0;
            model(3'($urandom), f7, $urandom, b, r, ill, lat);
            run_op(3'($urandom_range(0, 7)), f7, $urandom, b, 5'($urandom),
                   int'($urandom_range(0, 2)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
